// File: rtl/voice_allocator.sv
// Polyphonic note-to-voice allocator for a bank of DDS voices.
// Scans one voice per cycle, then commits a retrigger, free allocation or steal.
module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W     = 7,
    localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1,
    localparam int CW = $clog2(NUM_VOICES + 1),
    localparam int VW = NUM_VOICES * NOTE_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ev_valid,
    output logic                  ev_ready,
    input  logic                  ev_on,
    input  logic [NOTE_W-1:0]     ev_note,
    output logic [VW-1:0]         voice_note,
    output logic [NUM_VOICES-1:0] voice_gate,
    output logic [NUM_VOICES-1:0] voice_trig,
    output logic                  steal,
    output logic [CW-1:0]         active_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [IW-1:0] LAST = IW'(NUM_VOICES - 1);

    state_t                  state_q;
    logic                    ready_q;
    logic [VW-1:0]           notes_q;
    logic [NUM_VOICES-1:0]   gate_q;
    logic [NUM_VOICES-1:0]   trig_q;
    logic                    steal_q;
    logic [CW-1:0]           count_q;
    logic [IW-1:0]           ptr_q;
    logic [IW-1:0]           idx_q;
    logic                    on_q;
    logic [NOTE_W-1:0]       note_q;
    logic                    free_f_q;
    logic [IW-1:0]           free_i_q;
    logic                    match_f_q;
    logic [IW-1:0]           match_i_q;

    logic                    cur_gate;
    logic [NOTE_W-1:0]       cur_note;
    logic [NUM_VOICES-1:0]   gate_d;
    logic [VW-1:0]           notes_d;
    logic [NUM_VOICES-1:0]   trig_d;
    logic                    steal_d;
    logic [IW-1:0]           ptr_d;

    function automatic logic [CW-1:0] popcnt(
        input logic [NUM_VOICES-1:0] v
    );
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    always_comb begin
        cur_gate = gate_q[idx_q];
        cur_note = notes_q[idx_q*NOTE_W +: NOTE_W];
    end

    // Commit decision: match beats free, free beats steal.
    always_comb begin
        gate_d  = gate_q;
        notes_d = notes_q;
        trig_d  = '0;
        steal_d = 1'b0;
        ptr_d   = ptr_q;
        if (on_q) begin
            if (match_f_q) begin
                trig_d[match_i_q] = 1'b1;
            end else if (free_f_q) begin
                gate_d[free_i_q] = 1'b1;
                notes_d[free_i_q*NOTE_W +: NOTE_W] = note_q;
                trig_d[free_i_q] = 1'b1;
            end else begin
                notes_d[ptr_q*NOTE_W +: NOTE_W] = note_q;
                trig_d[ptr_q] = 1'b1;
                steal_d = 1'b1;
                ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
            end
        end else if (match_f_q) begin
            gate_d[match_i_q] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            ready_q   <= 1'b1;
            notes_q   <= '0;
            gate_q    <= '0;
            trig_q    <= '0;
            steal_q   <= 1'b0;
            count_q   <= '0;
            ptr_q     <= '0;
            idx_q     <= '0;
            on_q      <= 1'b0;
            note_q    <= '0;
            free_f_q  <= 1'b0;
            free_i_q  <= '0;
            match_f_q <= 1'b0;
            match_i_q <= '0;
        end else begin
            trig_q  <= '0;
            steal_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (ev_valid && ready_q) begin
                        on_q      <= ev_on;
                        note_q    <= ev_note;
                        free_f_q  <= 1'b0;
                        free_i_q  <= '0;
                        match_f_q <= 1'b0;
                        match_i_q <= '0;
                        idx_q     <= '0;
                        ready_q   <= 1'b0;
                        state_q   <= SCAN;
                    end
                end
                SCAN: begin
                    if (!cur_gate && !free_f_q) begin
                        free_f_q <= 1'b1;
                        free_i_q <= idx_q;
                    end
                    if (cur_gate && (cur_note == note_q)
                        && !match_f_q) begin
                        match_f_q <= 1'b1;
                        match_i_q <= idx_q;
                    end
                    if (idx_q == LAST) begin
                        state_q <= COMMIT;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                COMMIT: begin
                    gate_q  <= gate_d;
                    notes_q <= notes_d;
                    trig_q  <= trig_d;
                    steal_q <= steal_d;
                    ptr_q   <= ptr_d;
                    count_q <= popcnt(gate_d);
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ev_ready     = ready_q;
    assign voice_note   = notes_q;
    assign voice_gate   = gate_q;
    assign voice_trig   = trig_q;
    assign steal        = steal_q;
    assign active_count = count_q;

endmodule
